// File: rtl/spi_flash_responder_pkg.sv
// Shared opcodes, FSM state encoding and status-byte helper for the SPI flash responder.
`timescale 1ns/1ps
package spi_flash_responder_pkg;

    localparam logic [7:0] CMD_RDID = 8'h9F;
    localparam logic [7:0] CMD_RDSR = 8'h05;
    localparam logic [7:0] CMD_WREN = 8'h06;
    localparam logic [7:0] CMD_WRDI = 8'h04;
    localparam logic [7:0] CMD_READ = 8'h03;
    localparam logic [7:0] CMD_PP   = 8'h02;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_ID_OUT,
        ST_STAT_OUT,
        ST_RD_OUT,
        ST_WR_IN,
        ST_IGNORE
    } state_e;

    // WIP is always 0: programming completes instantly in this model.
    function automatic logic [7:0] status_byte(input logic wel);
        return {6'b0, wel, 1'b0};
    endfunction

endpackage

// File: rtl/spi_resp_ram.sv
// Single-port synchronous byte RAM, one-cycle read latency, no reset so it maps to block RAM.
`timescale 1ns/1ps
module spi_resp_ram #(
    parameter int ADDR_BITS = 10
) (
    input  logic                 clk_i,
    input  logic                 en_i,
    input  logic                 we_i,
    input  logic [ADDR_BITS-1:0] addr_i,
    input  logic [7:0]           wdata_i,
    output logic [7:0]           rdata_o
);
    logic [7:0] mem_q [2**ADDR_BITS];
    logic [7:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (en_i) begin
            if (we_i) mem_q[addr_i] <= wdata_i;
            else      rdata_q       <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/spi_flash_responder.sv
// SPI mode-0 flash responder: oversampled SCK/CSB/MOSI, decodes RDID/RDSR/WREN/WRDI/READ/PP
// and answers on MISO from an internal byte RAM.
`timescale 1ns/1ps
module spi_flash_responder
    import spi_flash_responder_pkg::*;
#(
    parameter int          ADDR_BITS = 10,
    parameter logic [23:0] JEDEC_ID  = 24'h1F2400
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic sck_i,
    input  logic csb_i,
    input  logic mosi_i,
    output logic miso_o,
    output logic miso_oe_o
);
    // state       | meaning
    // IDLE        | CSB high, waiting for CSB fall      CMD       | shifting in opcode
    // ADDR        | shifting in 3 address bytes         ID_OUT    | returning JEDEC ID then zeros
    // STAT_OUT    | returning status byte repeatedly    RD_OUT    | streaming memory bytes
    // WR_IN       | writing received bytes into page    IGNORE    | idle until CSB rise

    state_e               state_q, state_d;
    logic [2:0]           sck_q, csb_q;
    logic [1:0]           mosi_q;
    logic [2:0]           bit_cnt_q;
    logic [7:0]           sh_in_q, sh_out_q, tx_next_q, cmd_q, wr_data_q;
    logic [1:0]           addr_cnt_q, id_idx_q;
    logic [ADDR_BITS-1:0] addr_q;
    logic                 wel_q, rd_pend_q, rd_valid_q, wr_pend_q, wr_en_q;
    logic [7:0]           ram_rdata;

    logic       sck_rise, sck_fall, csb_rise, csb_fall, byte_done;
    logic       cmd_done, addr_last, rd_next, wr_next;
    logic [7:0] rx_byte;

    assign sck_rise  = sck_q[1] & ~sck_q[2];
    assign sck_fall  = ~sck_q[1] & sck_q[2];
    assign csb_rise  = csb_q[1] & ~csb_q[2];
    assign csb_fall  = ~csb_q[1] & csb_q[2];
    assign rx_byte   = {sh_in_q[6:0], mosi_q[1]};
    // A CSB rise in the same cycle as the 8th SCK rise discards the byte.
    assign byte_done = (state_q != ST_IDLE) & sck_rise & (bit_cnt_q == 3'd7) & ~csb_rise;
    assign miso_o    = sh_out_q[7];

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (csb_rise) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: if (csb_fall) state_d = ST_CMD;
                ST_CMD: begin
                    if (byte_done) begin
                        case (rx_byte)
                            CMD_RDID:         state_d = ST_ID_OUT;
                            CMD_RDSR:         state_d = ST_STAT_OUT;
                            CMD_READ, CMD_PP: state_d = ST_ADDR;
                            default:          state_d = ST_IGNORE;
                        endcase
                    end
                end
                ST_ADDR: begin
                    if (byte_done && addr_cnt_q == 2'd2)
                        state_d = (cmd_q == CMD_READ) ? ST_RD_OUT : ST_WR_IN;
                end
                default: state_d = state_q;
            endcase
        end
    end

    always_comb begin
        miso_oe_o = (state_q != ST_IDLE);
        cmd_done  = (state_q == ST_CMD) & byte_done;
        addr_last = (state_q == ST_ADDR) & byte_done & (addr_cnt_q == 2'd2);
        rd_next   = (state_q == ST_RD_OUT) & byte_done;
        wr_next   = (state_q == ST_WR_IN) & byte_done;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sck_q      <= '0;
            csb_q      <= '0;
            mosi_q     <= '0;
            bit_cnt_q  <= '0;
            sh_in_q    <= '0;
            sh_out_q   <= '0;
            tx_next_q  <= '0;
            cmd_q      <= '0;
            wr_data_q  <= '0;
            addr_cnt_q <= '0;
            id_idx_q   <= '0;
            addr_q     <= '0;
            wel_q      <= 1'b0;
            rd_pend_q  <= 1'b0;
            rd_valid_q <= 1'b0;
            wr_pend_q  <= 1'b0;
            wr_en_q    <= 1'b0;
        end else begin
            sck_q  <= {sck_q[1:0], sck_i};
            csb_q  <= {csb_q[1:0], csb_i};
            mosi_q <= {mosi_q[0], mosi_i};

            if (csb_fall || csb_rise) begin
                bit_cnt_q  <= '0;
                sh_in_q    <= '0;
                sh_out_q   <= '0;
                tx_next_q  <= '0;
                cmd_q      <= '0;
                addr_cnt_q <= '0;
                id_idx_q   <= '0;
            end else if (state_q != ST_IDLE) begin
                if (sck_rise) begin
                    bit_cnt_q <= bit_cnt_q + 3'd1;
                    sh_in_q   <= rx_byte;
                end
                // bit_cnt_q == 0 on a fall means a byte just ended: present the next response byte.
                if (sck_fall)
                    sh_out_q <= (bit_cnt_q == 3'd0) ? tx_next_q : {sh_out_q[6:0], 1'b0};

                if (cmd_done) begin
                    cmd_q    <= rx_byte;
                    id_idx_q <= 2'd1;
                    if (rx_byte == CMD_RDID)      tx_next_q <= JEDEC_ID[23:16];
                    else if (rx_byte == CMD_RDSR) tx_next_q <= status_byte(wel_q);
                    else                          tx_next_q <= 8'h00;
                end else if (byte_done && state_q == ST_ID_OUT) begin
                    case (id_idx_q)
                        2'd1:    tx_next_q <= JEDEC_ID[15:8];
                        2'd2:    tx_next_q <= JEDEC_ID[7:0];
                        default: tx_next_q <= 8'h00;
                    endcase
                    if (id_idx_q != 2'd3) id_idx_q <= id_idx_q + 2'd1;
                end else if (byte_done && state_q == ST_STAT_OUT) begin
                    tx_next_q <= status_byte(wel_q);
                end else if (byte_done) begin
                    tx_next_q <= 8'h00;
                end

                if (byte_done && state_q == ST_ADDR) begin
                    addr_q     <= ADDR_BITS'({addr_q, rx_byte});
                    addr_cnt_q <= addr_cnt_q + 2'd1;
                end
            end

            if (rd_valid_q) tx_next_q <= ram_rdata;

            if (rd_next) addr_q <= addr_q + ADDR_BITS'(1);
            // Page program increments only within the 256-byte page.
            if (wr_pend_q) addr_q <= {addr_q[ADDR_BITS-1:8], addr_q[7:0] + 8'd1};

            rd_pend_q  <= (addr_last & (cmd_q == CMD_READ)) | rd_next;
            rd_valid_q <= rd_pend_q;
            wr_pend_q  <= wr_next;
            if (wr_next) begin
                wr_data_q <= rx_byte;
                wr_en_q   <= wel_q;
            end

            if (csb_rise && cmd_q == CMD_PP)          wel_q <= 1'b0;
            else if (cmd_done && rx_byte == CMD_WREN) wel_q <= 1'b1;
            else if (cmd_done && rx_byte == CMD_WRDI) wel_q <= 1'b0;
        end
    end

    spi_resp_ram #(.ADDR_BITS(ADDR_BITS)) u_ram (
        .clk_i   (clk_i),
        .en_i    (rd_pend_q | (wr_pend_q & wr_en_q)),
        .we_i    (wr_pend_q & wr_en_q),
        .addr_i  (addr_q),
        .wdata_i (wr_data_q),
        .rdata_o (ram_rdata)
    );

endmodule
